// File: rtl/mac_rr_scheduler.sv
// Round-robin scheduler sharing one A*B+C multiply-add unit between N_REQ requesters.
// Results are returned tagged with the requester index over a single valid/ready port.
module mac_rr_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    input  logic [N_REQ*WIDTH-1:0] req_c,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH-1:0]       res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   res_ovf,
    output logic                   busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    grant;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic [ID_W-1:0]    op_id;
    logic [WIDTH-1:0]   op_a, op_b, op_c;
    logic [WIDTH-1:0]   sel_a, sel_b, sel_c;
    logic [2*WIDTH-1:0] sum;

    // Scan starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(last_grant) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[grant] = 1'b1;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
                sel_c = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    assign sum  = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b) + (2*WIDTH)'(op_c);
    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            op_a       <= '0;
            op_b       <= '0;
            op_c       <= '0;
            op_id      <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= '0;
            res_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        op_a       <= sel_a;
                        op_b       <= sel_b;
                        op_c       <= sel_c;
                        op_id      <= grant;
                        last_grant <= grant;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_data  <= sum[WIDTH-1:0];
                    res_ovf   <= |sum[2*WIDTH-1:WIDTH];
                    res_id    <= op_id;
                    res_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_rr_scheduler.sv
// Directed self-checking bench for mac_rr_scheduler: arbitration order, latency,
// overflow flag, backpressure and mid-operation reset.
module tb_mac_rr_scheduler;

    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = 2;

    logic                   clock;
    logic                   reset;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a, req_b, req_c;
    logic                   res_valid;
    logic                   res_ready;
    logic [WIDTH-1:0]       res_data;
    logic [ID_W-1:0]        res_id;
    logic                   res_ovf;
    logic                   busy;

    int checks   = 0;
    int failures = 0;

    mac_rr_scheduler #(
        .N_REQ(N_REQ),
        .WIDTH(WIDTH),
        .ID_W (ID_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_c    (req_c),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_id   (res_id),
        .res_ovf  (res_ovf),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c);
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
        req_c[i*WIDTH +: WIDTH] = WIDTH'(c);
    endtask

    task automatic apply_reset;
        reset     = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;
        #1;
    endtask

    // Runs one job on requester i alone; got=0 means no result within the cycle budget.
    task automatic do_job(input int i, input int a, input int b, input int c,
                          output bit got, output logic [WIDTH-1:0] d,
                          output logic [ID_W-1:0] id, output logic ovf);
        set_ops(i, a, b, c);
        req_valid = N_REQ'(1 << i);
        res_ready = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            tick;
            if (busy) req_valid = '0;
            if (res_valid) got = 1'b1;
        end
        d   = res_data;
        id  = res_id;
        ovf = res_ovf;
        req_valid = '0;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        apply_reset;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%0b exp=0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (res_data !== 8'd0) begin failures++; $display("FAIL reset_res_data got=%0d exp=0", res_data); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
        checks++; if (res_ovf !== 1'b0) begin failures++; $display("FAIL reset_res_ovf got=%0b exp=0", res_ovf); end
    endtask

    task automatic test_single_job;
        apply_reset;
        set_ops(0, 10, 20, 5);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_req_ready got=%b exp=0001", req_ready); end
        tick;
        req_valid = '0;
        set_ops(0, 99, 99, 99);
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_exec_ready got=%b exp=0000", req_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_exec_busy got=%0b exp=1", busy); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_exec_valid got=%0b exp=0", res_valid); end
        tick;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_done_valid got=%0b exp=1", res_valid); end
        checks++; if (res_data !== 8'd205) begin failures++; $display("FAIL single_data got=%0d exp=205", res_data); end
        checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", res_id); end
        checks++; if (res_ovf !== 1'b0) begin failures++; $display("FAIL single_ovf got=%0b exp=0", res_ovf); end
        res_ready = 1'b1;
        tick;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_after_valid got=%0b exp=0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_after_busy got=%0b exp=0", busy); end
        checks++; if (res_data !== 8'd205) begin failures++; $display("FAIL single_data_hold got=%0d exp=205", res_data); end
        res_ready = 1'b0;
    endtask

    task automatic test_all_four;
        logic [WIDTH-1:0] exp_data [4];
        logic [3:0]       exp_rdy  [4];
        exp_data = '{8'd2, 8'd5, 8'd8, 8'd11};
        exp_rdy  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        apply_reset;
        for (int i = 0; i < 4; i++) set_ops(i, i + 1, 2, i);
        res_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (req_ready !== exp_rdy[j]) begin failures++; $display("FAIL all4_grant job=%0d got=%b exp=%b", j, req_ready, exp_rdy[j]); end
            tick;
            tick;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL all4_valid job=%0d got=%0b exp=1", j, res_valid); end
            checks++; if (res_data !== exp_data[j]) begin failures++; $display("FAIL all4_data job=%0d got=%0d exp=%0d", j, res_data, exp_data[j]); end
            checks++; if (res_id !== ID_W'(j)) begin failures++; $display("FAIL all4_id job=%0d got=%0d exp=%0d", j, res_id, j); end
            tick;
        end
        req_valid = '0;
        tick;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL all4_idle_busy got=%0b exp=0", busy); end
        res_ready = 1'b0;
    endtask

    task automatic test_fairness;
        logic [ID_W-1:0] exp_id  [4];
        logic [3:0]      exp_rdy [4];
        exp_id  = '{2'd0, 2'd2, 2'd0, 2'd2};
        exp_rdy = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
        apply_reset;
        for (int i = 0; i < 4; i++) set_ops(i, i + 3, 1, 0);
        res_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        for (int j = 0; j < 4; j++) begin
            checks++; if (req_ready !== exp_rdy[j]) begin failures++; $display("FAIL fair_grant job=%0d got=%b exp=%b", j, req_ready, exp_rdy[j]); end
            tick;
            if (j == 0) req_valid = 4'b0101;
            tick;
            checks++; if (res_id !== exp_id[j]) begin failures++; $display("FAIL fair_id job=%0d got=%0d exp=%0d", j, res_id, exp_id[j]); end
            checks++; if (res_data !== WIDTH'(exp_id[j] + 3)) begin failures++; $display("FAIL fair_data job=%0d got=%0d exp=%0d", j, res_data, exp_id[j] + 3); end
            tick;
        end
        req_valid = '0;
        res_ready = 1'b0;
        tick;
    endtask

    task automatic test_overflow;
        int               req  [5];
        int               a    [5];
        int               b    [5];
        int               c    [5];
        logic [WIDTH-1:0] ed   [5];
        logic             eo   [5];
        bit               got;
        logic [WIDTH-1:0] d;
        logic [ID_W-1:0]  id;
        logic             ovf;
        req = '{1, 3, 2, 0, 1};
        a   = '{255, 16, 255, 15, 15};
        b   = '{255, 16, 1, 17, 17};
        c   = '{255, 1, 0, 0, 1};
        ed  = '{8'h00, 8'h01, 8'hFF, 8'hFF, 8'h00};
        eo  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset;
        for (int j = 0; j < 5; j++) begin
            do_job(req[j], a[j], b[j], c[j], got, d, id, ovf);
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL ovf_timeout row=%0d got=no_result exp=result", j);
            end else begin
                checks++; if (d !== ed[j]) begin failures++; $display("FAIL ovf_data row=%0d got=%h exp=%h", j, d, ed[j]); end
                checks++; if (ovf !== eo[j]) begin failures++; $display("FAIL ovf_flag row=%0d got=%0b exp=%0b", j, ovf, eo[j]); end
                checks++; if (id !== ID_W'(req[j])) begin failures++; $display("FAIL ovf_id row=%0d got=%0d exp=%0d", j, id, req[j]); end
            end
        end
    endtask

    task automatic test_backpressure;
        apply_reset;
        for (int i = 0; i < 4; i++) set_ops(i, i + 1, 3, 1);
        res_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        tick;
        tick;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%0b exp=1", res_valid); end
        checks++; if (res_data !== 8'd4) begin failures++; $display("FAIL bp_data got=%0d exp=4", res_data); end
        for (int k = 0; k < 5; k++) begin
            tick;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%0b exp=1", k, res_valid); end
            checks++; if (res_data !== 8'd4) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%0d exp=4", k, res_data); end
            checks++; if (res_id !== 2'd0) begin failures++; $display("FAIL bp_hold_id cyc=%0d got=%0d exp=0", k, res_id); end
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_hold_ready cyc=%0d got=%b exp=0000", k, req_ready); end
        end
        res_ready = 1'b1;
        req_valid = '0;
        tick;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got=%0b exp=0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_release_busy got=%0b exp=0", busy); end
        tick;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_single_transfer got=%0b exp=0", res_valid); end
        res_ready = 1'b0;
    endtask

    task automatic test_reset_midop;
        apply_reset;
        for (int i = 0; i < 4; i++) set_ops(i, 7, 7, i);
        res_ready = 1'b1;
        req_valid = 4'b1111;
        #1;
        tick;
        tick;
        tick;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_rr_advance got=%b exp=0010", req_ready); end
        tick;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_exec_busy got=%0b exp=1", busy); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_exec_rst_valid got=%0b exp=0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_exec_rst_busy got=%0b exp=0", busy); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_exec_rst_grant got=%b exp=0001", req_ready); end
        res_ready = 1'b0;
        tick;
        tick;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL mid_done_valid got=%0b exp=1", res_valid); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mid_done_rst_valid got=%0b exp=0", res_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_done_rst_busy got=%0b exp=0", busy); end
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_done_rst_grant got=%b exp=0001", req_ready); end
        checks++; if (res_data !== 8'd0) begin failures++; $display("FAIL mid_done_rst_data got=%0d exp=0", res_data); end
        req_valid = '0;
        tick;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        res_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_c     = '0;
        test_reset;
        test_single_job;
        test_all_four;
        test_fairness;
        test_overflow;
        test_backpressure;
        test_reset_midop;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
